// File: rtl/dl_multichan_frame_buffer.sv
// Multi-channel ping-pong frame buffer: per-channel writers fill two banks of FRAME_LEN words,
// and a single round-robin reader drains completed frames onto one shared output bus.
module dl_multichan_frame_buffer #(
    parameter int unsigned CH_NUM    = 4,
    parameter int unsigned DATA_W    = 10,
    parameter int unsigned FRAME_LEN = 128,
    localparam int unsigned ADDR_W   = $clog2(FRAME_LEN),
    localparam int unsigned CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
    input  logic                       clk,
    input  logic                       nRst,
    input  logic [CH_NUM*DATA_W-1:0]   inData,
    input  logic [CH_NUM-1:0]          inDataEn,
    input  logic [CH_NUM-1:0]          inSof,
    input  logic                       outReady,
    output logic [DATA_W-1:0]          outData,
    output logic                       outDataEn,
    output logic [CH_W-1:0]            outChan,
    output logic                       outSof,
    output logic                       outEof,
    output logic [2*CH_NUM-1:0]        bankFull,
    output logic [CH_NUM-1:0]          ovfFlag,
    output logic [15:0]                dropCnt
);

    localparam int unsigned RAM_DEPTH = 2 << ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_LEN - 1);

    typedef enum logic [1:0] {StIdle, StBurst, StRelease} state_e;

    logic [DATA_W-1:0] mem [CH_NUM][RAM_DEPTH];

    // Writer state
    logic [CH_NUM-1:0]              wr_bank_q, wr_bank_d;
    logic [CH_NUM-1:0]              in_frame_q, in_frame_d;
    logic [CH_NUM-1:0][ADDR_W-1:0]  wr_addr_q, wr_addr_d;
    logic [CH_NUM-1:0]              ovf_q, ovf_d;
    logic [15:0]                    drop_cnt_q, drop_cnt_d;
    logic [CH_NUM-1:0][1:0]         bank_full_q, bank_full_d;
    logic [CH_NUM-1:0][1:0]         set_full, clr_full;
    logic [CH_NUM-1:0]              we;
    logic [CH_NUM-1:0][ADDR_W:0]    wa;
    logic [4:0]                     drops;
    logic [16:0]                    drop_sum;

    // Reader state
    state_e                         state_q, state_d;
    logic [CH_W-1:0]                rd_chan_q, rd_chan_d;
    logic [ADDR_W-1:0]              rd_addr_q, rd_addr_d;
    logic [CH_NUM-1:0]              rd_bank_q, rd_bank_d;
    logic [CH_W-1:0]                rr_ptr_q, rr_ptr_d;
    logic                           issue;
    logic                           cand_found;
    logic [CH_W-1:0]                cand;
    logic [CH_W-1:0]                scan_ch;
    logic [ADDR_W:0]                rd_word_addr;

    logic                           out_en_q, out_en_d;
    logic                           out_sof_q, out_sof_d;
    logic                           out_eof_q, out_eof_d;
    logic [DATA_W-1:0]              out_data_q;

    always_comb begin
        wr_bank_d  = wr_bank_q;
        in_frame_d = in_frame_q;
        wr_addr_d  = wr_addr_q;
        ovf_d      = ovf_q;
        set_full   = '0;
        we         = '0;
        wa         = '0;
        drops      = '0;
        for (int c = 0; c < CH_NUM; c++) begin
            wa[c] = {wr_bank_q[c], wr_addr_q[c]};
            if (inDataEn[c]) begin
                if (inSof[c]) begin
                    if (bank_full_q[c][wr_bank_q[c]]) begin
                        in_frame_d[c] = 1'b0;
                        ovf_d[c]      = 1'b1;
                        drops         = drops + 5'd1;
                    end else begin
                        // A sof mid-frame lands here too and silently restarts the bank.
                        we[c]         = 1'b1;
                        wa[c]         = {wr_bank_q[c], {ADDR_W{1'b0}}};
                        wr_addr_d[c]  = ADDR_W'(1);
                        in_frame_d[c] = 1'b1;
                    end
                end else if (in_frame_q[c]) begin
                    we[c] = 1'b1;
                    if (wr_addr_q[c] == LAST_ADDR) begin
                        set_full[c][wr_bank_q[c]] = 1'b1;
                        wr_bank_d[c]  = ~wr_bank_q[c];
                        in_frame_d[c] = 1'b0;
                        wr_addr_d[c]  = '0;
                    end else begin
                        wr_addr_d[c] = wr_addr_q[c] + ADDR_W'(1);
                    end
                end
            end
        end
        drop_sum   = {1'b0, drop_cnt_q} + 17'(drops);
        drop_cnt_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    always_comb begin
        cand_found = 1'b0;
        cand       = '0;
        scan_ch    = '0;
        // Scan starts just after the last-served channel.
        for (int i = 1; i <= CH_NUM; i++) begin
            scan_ch = CH_W'((32'(rr_ptr_q) + 32'(i)) % CH_NUM);
            if (!cand_found && bank_full_q[scan_ch][rd_bank_q[scan_ch]]) begin
                cand_found = 1'b1;
                cand       = scan_ch;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rd_chan_d = rd_chan_q;
        rd_addr_d = rd_addr_q;
        rd_bank_d = rd_bank_q;
        rr_ptr_d  = rr_ptr_q;
        clr_full  = '0;
        issue     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (cand_found) begin
                    state_d   = StBurst;
                    rd_chan_d = cand;
                    rd_addr_d = '0;
                end
            end
            StBurst: begin
                if (outReady) begin
                    issue = 1'b1;
                    if (rd_addr_q == LAST_ADDR) begin
                        state_d   = StRelease;
                        rd_addr_d = '0;
                    end else begin
                        rd_addr_d = rd_addr_q + ADDR_W'(1);
                    end
                end
            end
            StRelease: begin
                clr_full[rd_chan_q][rd_bank_q[rd_chan_q]] = 1'b1;
                rd_bank_d[rd_chan_q] = ~rd_bank_q[rd_chan_q];
                rr_ptr_d = rd_chan_q;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Writer set and reader clear always target different banks of a channel.
        bank_full_d  = (bank_full_q | set_full) & ~clr_full;
        out_en_d     = issue;
        out_sof_d    = issue && (rd_addr_q == '0);
        out_eof_d    = issue && (rd_addr_q == LAST_ADDR);
        rd_word_addr = {rd_bank_q[rd_chan_q], rd_addr_q};
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < CH_NUM; c++) begin
            if (we[c]) begin
                mem[c][wa[c]] <= inData[c*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!nRst) begin
            wr_bank_q   <= '0;
            in_frame_q  <= '0;
            wr_addr_q   <= '0;
            ovf_q       <= '0;
            drop_cnt_q  <= '0;
            bank_full_q <= '0;
            state_q     <= StIdle;
            rd_chan_q   <= '0;
            rd_addr_q   <= '0;
            rd_bank_q   <= '0;
            rr_ptr_q    <= CH_W'(CH_NUM - 1);
            out_en_q    <= 1'b0;
            out_sof_q   <= 1'b0;
            out_eof_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            wr_bank_q   <= wr_bank_d;
            in_frame_q  <= in_frame_d;
            wr_addr_q   <= wr_addr_d;
            ovf_q       <= ovf_d;
            drop_cnt_q  <= drop_cnt_d;
            bank_full_q <= bank_full_d;
            state_q     <= state_d;
            rd_chan_q   <= rd_chan_d;
            rd_addr_q   <= rd_addr_d;
            rd_bank_q   <= rd_bank_d;
            rr_ptr_q    <= rr_ptr_d;
            out_en_q    <= out_en_d;
            out_sof_q   <= out_sof_d;
            out_eof_q   <= out_eof_d;
            if (issue) begin
                out_data_q <= mem[rd_chan_q][rd_word_addr];
            end
        end
    end

    assign outData   = out_data_q;
    assign outDataEn = out_en_q;
    assign outChan   = rd_chan_q;
    assign outSof    = out_sof_q;
    assign outEof    = out_eof_q;
    assign bankFull  = bank_full_q;
    assign ovfFlag   = ovf_q;
    assign dropCnt   = drop_cnt_q;

endmodule

// File: tb/tb_dl_multichan_frame_buffer.sv
// Directed bench for dl_multichan_frame_buffer with CH_NUM=4, FRAME_LEN=8.
module tb_dl_multichan_frame_buffer;

    logic        clk = 1'b0;
    logic        nRst;
    logic [39:0] in_data;
    logic [3:0]  in_en;
    logic [3:0]  in_sof;
    logic        out_ready;
    logic [9:0]  out_data;
    logic        out_en;
    logic [1:0]  out_chan;
    logic        out_sof;
    logic        out_eof;
    logic [7:0]  bank_full;
    logic [3:0]  ovf_flag;
    logic [15:0] drop_cnt;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int last_drive_cyc = 0;
    int n0;

    logic [9:0] q_data[$];
    logic [1:0] q_chan[$];
    bit         q_sof[$];
    bit         q_eof[$];
    int         q_cyc[$];

    dl_multichan_frame_buffer #(
        .CH_NUM   (4),
        .DATA_W   (10),
        .FRAME_LEN(8)
    ) dut (
        .clk      (clk),
        .nRst     (nRst),
        .inData   (in_data),
        .inDataEn (in_en),
        .inSof    (in_sof),
        .outReady (out_ready),
        .outData  (out_data),
        .outDataEn(out_en),
        .outChan  (out_chan),
        .outSof   (out_sof),
        .outEof   (out_eof),
        .bankFull (bank_full),
        .ovfFlag  (ovf_flag),
        .dropCnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (out_en === 1'b1) begin
            q_data.push_back(out_data);
            q_chan.push_back(out_chan);
            q_sof.push_back(out_sof);
            q_eof.push_back(out_eof);
            q_cyc.push_back(cyc);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_q();
        q_data.delete();
        q_chan.delete();
        q_sof.delete();
        q_eof.delete();
        q_cyc.delete();
    endtask

    task automatic do_reset();
        nRst = 1'b0;
        tick();
        tick();
        nRst = 1'b1;
        clear_q();
    endtask

    // Channel c of mask gets words base + c*step + i, sof on word 0.
    task automatic send(input logic [3:0] mask, input int base, input int step, input int n);
        for (int i = 0; i < n; i++) begin
            for (int c = 0; c < 4; c++) in_data[c*10 +: 10] = 10'(base + c*step + i);
            in_en  = mask;
            in_sof = (i == 0) ? mask : 4'b0000;
            last_drive_cyc = cyc;
            tick();
        end
        in_en  = 4'b0000;
        in_sof = 4'b0000;
    endtask

    task automatic wait_words(input string tag, input int n, input int budget);
        int k = 0;
        while (q_data.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(q_data.size() >= n), 32'd1);
    endtask

    task automatic check_frame(input string tag, input int k0, input int ch, input int base);
        if (q_data.size() < k0 + 8) begin
            chk({tag, "_len"}, 32'(q_data.size()), 32'(k0 + 8));
            return;
        end
        for (int i = 0; i < 8; i++) begin
            chk({tag, "_data"}, 32'(q_data[k0+i]), 32'(base + i));
            chk({tag, "_chan"}, 32'(q_chan[k0+i]), 32'(ch));
            chk({tag, "_sof"}, 32'(q_sof[k0+i]), 32'(i == 0));
            chk({tag, "_eof"}, 32'(q_eof[k0+i]), 32'(i == 7));
        end
    endtask

    initial begin
        nRst      = 1'b0;
        in_data   = '0;
        in_en     = '0;
        in_sof    = '0;
        out_ready = 1'b0;
        tick();
        tick();
        chk("rst_en", 32'(out_en), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_sofeof", 32'({out_sof, out_eof}), 32'd0);
        chk("rst_chan", 32'(out_chan), 32'd0);
        chk("rst_full", 32'(bank_full), 32'd0);
        chk("rst_ovf", 32'(ovf_flag), 32'd0);
        chk("rst_drop", 32'(drop_cnt), 32'd0);
        nRst = 1'b1;
        clear_q();

        // Single channel frame, latency and bankFull lifetime
        out_ready = 1'b1;
        send(4'b0100, 'h200, 0, 8);
        chk("t1_full_set", 32'(bank_full), 32'h10);
        wait_words("t1_wait", 8, 40);
        repeat (10) tick();
        chk("t1_count", 32'(q_data.size()), 32'd8);
        check_frame("t1", 0, 2, 'h200);
        if (q_cyc.size() > 0) chk("t1_latency", 32'(q_cyc[0] - last_drive_cyc), 32'd3);
        chk("t1_full_clr", 32'(bank_full), 32'd0);

        // All channels complete together: round-robin order and spacing
        do_reset();
        out_ready = 1'b1;
        send(4'b1111, 'h040, 'h80, 8);
        wait_words("t2_wait", 32, 100);
        repeat (10) tick();
        chk("t2_count", 32'(q_data.size()), 32'd32);
        for (int f = 0; f < 4; f++) check_frame("t2", 8*f, f, 'h040 + 'h80*f);
        if (q_cyc.size() >= 32) begin
            for (int f = 1; f < 4; f++) chk("t2_gap", 32'(q_cyc[8*f] - q_cyc[8*(f-1)]), 32'd10);
            chk("t2_burst", 32'(q_cyc[7] - q_cyc[0]), 32'd7);
        end
        chk("t2_full_clr", 32'(bank_full), 32'd0);

        // Pulsed ready during a burst
        do_reset();
        out_ready = 1'b0;
        send(4'b1000, 'h300, 0, 8);
        for (int k = 0; k < 60 && q_data.size() < 8; k++) begin
            out_ready = (k % 3 == 0);
            tick();
        end
        out_ready = 1'b0;
        repeat (10) tick();
        chk("t3_count", 32'(q_data.size()), 32'd8);
        check_frame("t3", 0, 3, 'h300);

        // Overflow on channel 0 while output is stalled
        do_reset();
        out_ready = 1'b0;
        send(4'b0001, 'h010, 0, 8);
        send(4'b0001, 'h020, 0, 8);
        send(4'b0001, 'h030, 0, 8);
        chk("t4_full", 32'(bank_full), 32'h03);
        chk("t4_ovf", 32'(ovf_flag), 32'h1);
        chk("t4_drop", 32'(drop_cnt), 32'd1);
        chk("t4_stall", 32'(q_data.size()), 32'd0);
        out_ready = 1'b1;
        wait_words("t4_wait", 16, 80);
        repeat (12) tick();
        chk("t4_count", 32'(q_data.size()), 32'd16);
        check_frame("t4a", 0, 0, 'h010);
        check_frame("t4b", 8, 0, 'h020);
        chk("t4_full_clr", 32'(bank_full), 32'd0);
        chk("t4_ovf_sticky", 32'(ovf_flag), 32'h1);

        // Two channels drop in the same cycle
        do_reset();
        out_ready = 1'b0;
        send(4'b0110, 'h100, 'h40, 8);
        send(4'b0110, 'h108, 'h40, 8);
        send(4'b0110, 'h110, 'h40, 8);
        chk("t4c_drop", 32'(drop_cnt), 32'd2);
        chk("t4c_ovf", 32'(ovf_flag), 32'h6);
        chk("t4c_full", 32'(bank_full), 32'h3C);

        // Restart mid-frame
        do_reset();
        out_ready = 1'b1;
        send(4'b0010, 'h150, 0, 4);
        send(4'b0010, 'h1A0, 0, 8);
        wait_words("t5_wait", 8, 40);
        repeat (12) tick();
        chk("t5_count", 32'(q_data.size()), 32'd8);
        check_frame("t5", 0, 1, 'h1A0);
        chk("t5_drop", 32'(drop_cnt), 32'd0);
        chk("t5_ovf", 32'(ovf_flag), 32'd0);

        // Reset in the middle of a burst
        do_reset();
        out_ready = 1'b1;
        send(4'b0001, 'h0F0, 0, 8);
        wait_words("t6_wait", 3, 40);
        nRst = 1'b0;
        tick();
        chk("t6_en", 32'(out_en), 32'd0);
        chk("t6_data", 32'(out_data), 32'd0);
        chk("t6_sofeof", 32'({out_sof, out_eof}), 32'd0);
        chk("t6_full", 32'(bank_full), 32'd0);
        n0 = q_data.size();
        nRst = 1'b1;
        repeat (20) tick();
        chk("t6_quiet", 32'(q_data.size()), 32'(n0));
        if (q_data.size() > 0) chk("t6_first", 32'(q_data[0]), 32'h0F0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dl_multichan_frame_buffer.md
Name: dl_multichan_frame_buffer

Overview:
Parametrised successor to the single-channel downlink RAM write/read pair. It accepts CH_NUM independent streams of already-encoded 10-bit words and stores each channel in a private ping-pong (two-bank) frame buffer of FRAME_LEN words. Completed frames are drained by a single round-robin reader onto one shared output bus, with ready backpressure, channel tagging and frame delimiters. It sits between the per-channel 8b/10b encoders and the serial output stage.

Parameters:
CH_NUM, 4, number of input channels (1..16)
DATA_W, 10, word width
FRAME_LEN, 128, words per frame (>=2)
Derived localparams: ADDR_W = clog2(FRAME_LEN), CH_W = max(1, clog2(CH_NUM)).

Ports:
clk  in  1  single clock for the whole block
nRst  in  1  reset, synchronous, active-low
inData  in  CH_NUM*DATA_W  channel c at [c*DATA_W +: DATA_W]
inDataEn  in  CH_NUM  per-channel word valid
inSof  in  CH_NUM  per-channel first-word marker, qualified by inDataEn
outReady  in  1  downstream may accept; 1-cycle latency
outData  out  DATA_W  output word
outDataEn  out  1  outData valid
outChan  out  CH_W  source channel of current frame
outSof  out  1  first word of frame
outEof  out  1  last word of frame
bankFull  out  2*CH_NUM  bit 2c+b = channel c bank b holds a complete frame
ovfFlag  out  CH_NUM  sticky per-channel frame-drop flag
dropCnt  out  16  total dropped frames, saturates at 16'hFFFF

Behaviour:
- Reset (nRst=0 at posedge clk): all outputs 0; bankFull, ovfFlag, dropCnt cleared; wrBank/rdBank = 0 for every channel; writers not in-frame; reader in IDLE; round-robin pointer set so channel 0 is checked first.
- Storage: one 1W1R synchronous RAM per channel, 2*FRAME_LEN deep, address {bank, ADDR_W addr}. Read data is valid 1 cycle after read issue.
- Writer, per channel, independent:
  - inDataEn&inSof, bank wrBank free: write at addr 0, next addr 1, in-frame.
  - inDataEn&inSof, bank wrBank full: discard frame, not in-frame, ovfFlag[c]<=1, dropCnt+1 (saturating). Multiple channels dropping in the same cycle add their count in that cycle.
  - inSof mid-frame: partial frame discarded silently and not counted; restart at addr 0 of the same bank.
  - inDataEn without inSof while not in-frame: ignored.
  - Write at addr FRAME_LEN-1 at cycle T: bankFull set at T+1, wrBank toggles, writer leaves in-frame.
- Reader FSM:
  - IDLE: scan channels round-robin starting after the last-served channel; select the first c with bankFull[2c+rdBank[c]]. Next state BURST, capture channel. No candidate: stay.
  - BURST: each cycle with outReady=1, issue read at rdAddr and increment. Issuing addr FRAME_LEN-1 leads to RELEASE. outReady=0: no issue, hold.
  - RELEASE: clear that bankFull bit, toggle rdBank[c], update the round-robin pointer, go to IDLE.
  - Issued reads produce outDataEn=1 the next cycle, regardless of outReady at that time. outSof is set with word 0, outEof with word FRAME_LEN-1. outChan is held for the whole frame. Otherwise outDataEn/outSof/outEof = 0.
- Latency: last input word written at T leads to bankFull at T+1, select at T+1, first issue at T+2 if ready, first outDataEn at T+3 (reader idle, no contention).
- Simultaneous writer set (one bank) and reader clear (other bank) on the same channel in the same cycle: both take effect.
- Fairness: with all channels continuously full, frames are emitted in order 0,1,2,…,CH_NUM-1,0,…
- Reset mid-operation: in-flight frames are abandoned and no partial frame is output after reset.

Test Plan:
- CH_NUM=4, FRAME_LEN=8. Ch2 sends sof + words 0x200..0x207 with ready held 1. Output is 8 words 0x200..0x207, outChan=2, outSof on the 1st word, outEof on the 8th, first outDataEn 3 cycles after the last write; bankFull bit 4 set then cleared.
- All 4 channels complete a frame in the same cycle. Output frames appear in channel order 0,1,2,3, back-to-back with one IDLE and one RELEASE cycle between frames.
- outReady pulsed 1-0-0-1… during a burst. No word is lost or duplicated; exactly one word may still arrive after ready falls; the sequence stays contiguous.
- Ch0 writes 3 frames while outReady=0. Frames 1 and 2 fill both banks; the 3rd is dropped: ovfFlag=4'b0001, dropCnt=1. Raising ready then outputs the first two frames intact.
- Ch1 sends 4 words, then a new sof with 8 words 0x1A0..0x1A7. Only the 8-word frame is output; dropCnt stays 0.
- nRst=0 for 1 cycle in the middle of a burst. All outputs 0 next cycle, bankFull=0, and no further words until new frames arrive.
